alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 22 ++
 rtl/adder_w.sv | 18 +
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and controller state encoding shared by the
// sequential ALU and anything that drives or checks it.
package alu_pkg;

   localparam logic [3:0] OP_ADD     = 4'd0;
   localparam logic [3:0] OP_ABSDIFF = 4'd1;
   localparam logic [3:0] OP_GT      = 4'd2;
   localparam logic [3:0] OP_OR      = 4'd3;
   localparam logic [3:0] OP_AND     = 4'd4;
   localparam logic [3:0] OP_SUB     = 4'd5;
   localparam logic [3:0] OP_XOR     = 4'd6;
   localparam logic [3:0] OP_MUL     = 4'd7;
   localparam logic [3:0] OP_SHL     = 4'd8;
   localparam logic [3:0] OP_SHR     = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_w.sv
// adder_w: WIDTH-bit ripple-style adder with carry in/out.
//   a, b  : addends
//   cin   : carry in
//   sum   : low WIDTH bits of a + b + cin
//   cout  : carry out of the top bit
module adder_w #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_seq.sv
// alu_seq: ALU with valid/ready handshakes on both sides.
//   Single-cycle ops return a result one cycle after accept; MUL runs an
//   iterative shift-add over WIDTH cycles and then holds the result in DONE.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake (in1, in2, opcode)
//   out_valid/out_ready  : result handshake (result, zero, carry)
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry
);

   localparam int             SH_W  = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ZEROS = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] LAST  = WIDTH'(WIDTH - 1);

   state_t             state_r;
   logic [WIDTH-1:0]   mcand_r;
   logic [2*WIDTH-1:0] prod_r;
   logic [WIDTH-1:0]   cnt_r;

   logic               is_sub_s;
   logic [WIDTH-1:0]   add_b_s;
   logic [WIDTH-1:0]   add_sum_s;
   logic               add_cout_s;
   logic [WIDTH-1:0]   mul_b_s;
   logic [WIDTH-1:0]   mul_sum_s;
   logic               mul_cout_s;
   logic [2*WIDTH-1:0] prod_next_s;
   logic [WIDTH-1:0]   alu_res_s;
   logic               alu_carry_s;
   logic               accept_s;
   logic               start_mul_s;

   assign in_ready = (state_r == IDLE) && (!out_valid || out_ready);
   assign accept_s = in_valid && in_ready;
   assign start_mul_s = (opcode == OP_MUL) && (MUL_EN != 0);

   // Every opcode except ADD runs the shared adder as in1 - in2 (b inverted, cin=1).
   assign is_sub_s = (opcode != OP_ADD);
   assign add_b_s  = is_sub_s ? ~in2 : in2;

   adder_w #(.WIDTH(WIDTH)) u_addsub (
      .a    (in1),
      .b    (add_b_s),
      .cin  (is_sub_s),
      .sum  (add_sum_s),
      .cout (add_cout_s)
   );

   // Right-shifting shift-add: the upper half accumulates the multiplicand
   // when the current multiplier bit (prod_r[0]) is set, then all shifts right.
   assign mul_b_s = prod_r[0] ? mcand_r : ZEROS;

   adder_w #(.WIDTH(WIDTH)) u_mulstep (
      .a    (prod_r[2*WIDTH-1:WIDTH]),
      .b    (mul_b_s),
      .cin  (1'b0),
      .sum  (mul_sum_s),
      .cout (mul_cout_s)
   );

   assign prod_next_s = {mul_cout_s, mul_sum_s, prod_r[WIDTH-1:1]};

   // Single-cycle result and carry for the opcode currently presented.
   always_comb begin
      alu_res_s   = ZEROS;
      alu_carry_s = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res_s   = add_sum_s;
            alu_carry_s = add_cout_s;
         end
         // No borrow means in1 >= in2; otherwise negate the wrapped difference.
         OP_ABSDIFF: alu_res_s = add_cout_s ? add_sum_s : (~add_sum_s + ONE);
         OP_GT:      alu_res_s = (add_cout_s && (add_sum_s != ZEROS)) ? ONES : ZEROS;
         OP_OR:      alu_res_s = in1 | in2;
         OP_AND:     alu_res_s = in1 & in2;
         OP_SUB: begin
            alu_res_s   = add_sum_s;
            alu_carry_s = ~add_cout_s;
         end
         OP_XOR:     alu_res_s = in1 ^ in2;
         OP_SHL:     alu_res_s = in1 << in2[SH_W-1:0];
         OP_SHR:     alu_res_s = in1 >> in2[SH_W-1:0];
         default: begin
            alu_res_s   = ZEROS;
            alu_carry_s = 1'b0;
         end
      endcase
   end

   // Controller FSM with registered result, flags and multiplier state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         out_valid <= 1'b0;
         result    <= ZEROS;
         zero      <= 1'b0;
         carry     <= 1'b0;
         mcand_r   <= ZEROS;
         prod_r    <= {2*WIDTH{1'b0}};
         cnt_r     <= ZEROS;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s && start_mul_s) begin
                  state_r   <= MUL;
                  mcand_r   <= in1;
                  prod_r    <= {ZEROS, in2};
                  cnt_r     <= ZEROS;
                  out_valid <= 1'b0;
               end else if (accept_s) begin
                  result    <= alu_res_s;
                  zero      <= (alu_res_s == ZEROS);
                  carry     <= alu_carry_s;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end else begin
                  out_valid <= out_valid;
               end
            end
            MUL: begin
               prod_r <= prod_next_s;
               cnt_r  <= cnt_r + ONE;
               if (cnt_r == LAST) begin
                  state_r   <= DONE;
                  result    <= prod_next_s[WIDTH-1:0];
                  zero      <= (prod_next_s[WIDTH-1:0] == ZEROS);
                  carry     <= |prod_next_s[2*WIDTH-1:WIDTH];
                  out_valid <= 1'b1;
               end else begin
                  state_r <= MUL;
               end
            end
            // Handoff cycle returns to IDLE; in_ready is low here so nothing is accepted.
            DONE: begin
               if (out_ready) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven and scoreboard-checked bench for alu_seq (WIDTH=8).
module tb_alu_seq;
   import alu_pkg::*;

   logic       clk, rst, in_valid, in_ready, out_valid, out_ready, zero, carry;
   logic [7:0] in1, in2, result;
   logic [3:0] opcode;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       z;
      logic       c;
   } vec_t;

   vec_t       tbl[$];
   logic [9:0] sb_q[$];
   logic [9:0] exp_pop;
   int         n_vec = 0, n_bad = 0, n_pop = 0, n_push = 0, n_drop = 0;

   alu_seq #(.WIDTH(8), .MUL_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .opcode(opcode), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .carry(carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] res, input logic z, input logic c);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.z = z; v.c = c;
      return v;
   endfunction

   // Reference model on plain integers: returns {result, zero, carry}.
   function automatic logic [9:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int unsigned ia, ib, r, c;
      logic [7:0]  r8;
      ia = a; ib = b; r = 0; c = 0;
      case (op)
         4'd0: begin r = ia + ib; c = (r > 255) ? 1 : 0; end
         4'd1: r = (ia > ib) ? ia - ib : ib - ia;
         4'd2: r = (ia > ib) ? 255 : 0;
         4'd3: r = ia | ib;
         4'd4: r = ia & ib;
         4'd5: begin r = ia + 256 - ib; c = (ib > ia) ? 1 : 0; end
         4'd6: r = ia ^ ib;
         4'd7: begin r = ia * ib; c = (r > 255) ? 1 : 0; end
         4'd8: r = ia << (ib % 8);
         4'd9: r = ia >> (ib % 8);
         default: r = 0;
      endcase
      r8 = r[7:0];
      return {r8, (r8 == 8'h00), c[0]};
   endfunction

   // Scoreboard: every result handed off is popped and compared in order.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got %h with no result outstanding", {result, zero, carry});
         end else begin
            exp_pop = sb_q.pop_front();
            n_pop++;
            chk("result_zero_carry", {22'd0, result, zero, carry}, {22'd0, exp_pop});
         end
      end
   end

   // Present one operation and wait (bounded) for it to be accepted.
   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [9:0] e);
      int t;
      opcode = op; in1 = a; in2 = b; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 60) begin
         @(posedge clk); #2;
         t++;
      end
      if (!in_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, expected 1", t);
         in_valid = 1'b0;
      end else begin
         sb_q.push_back(e);
         n_push++;
         @(posedge clk); #2;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 100) begin
         @(posedge clk); #2;
         t++;
      end
      chk("drain", sb_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1);
   end

   initial begin
      int lat, t;
      logic [9:0] hold;
      logic       seen;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in1 = 8'h00; in2 = 8'h00; opcode = 4'h0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      chk("rst_carry", carry, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;

      tbl.push_back(mk(OP_ADD,     8'hF0, 8'h20, 8'h10, 1'b0, 1'b1));
      tbl.push_back(mk(OP_SUB,     8'h05, 8'h05, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_ABSDIFF, 8'h03, 8'h09, 8'h06, 1'b0, 1'b0));
      tbl.push_back(mk(OP_ABSDIFF, 8'h09, 8'h03, 8'h06, 1'b0, 1'b0));
      tbl.push_back(mk(OP_ABSDIFF, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_GT,      8'h09, 8'h03, 8'hFF, 1'b0, 1'b0));
      tbl.push_back(mk(OP_GT,      8'h05, 8'h05, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_GT,      8'h03, 8'h09, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_OR,      8'hA0, 8'h0F, 8'hAF, 1'b0, 1'b0));
      tbl.push_back(mk(OP_AND,     8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0));
      tbl.push_back(mk(OP_SUB,     8'h03, 8'h09, 8'hFA, 1'b0, 1'b1));
      tbl.push_back(mk(OP_XOR,     8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_XOR,     8'h5A, 8'h0F, 8'h55, 1'b0, 1'b0));
      tbl.push_back(mk(OP_SHL,     8'h81, 8'h01, 8'h02, 1'b0, 1'b0));
      tbl.push_back(mk(OP_SHL,     8'h81, 8'h00, 8'h81, 1'b0, 1'b0));
      tbl.push_back(mk(OP_SHR,     8'h81, 8'h09, 8'h40, 1'b0, 1'b0));
      tbl.push_back(mk(OP_SHR,     8'h80, 8'h07, 8'h01, 1'b0, 1'b0));
      tbl.push_back(mk(OP_SHR,     8'h81, 8'h00, 8'h81, 1'b0, 1'b0));
      tbl.push_back(mk(4'hC,       8'hFF, 8'h00, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(4'hF,       8'h12, 8'h34, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_MUL,     8'h13, 8'h11, 8'h43, 1'b0, 1'b1));
      tbl.push_back(mk(OP_MUL,     8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0));
      tbl.push_back(mk(OP_MUL,     8'h00, 8'h55, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_ADD,     8'hFF, 8'h01, 8'h00, 1'b1, 1'b1));

      foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].res, tbl[i].z, tbl[i].c});
      drain();

      for (int i = 0; i < 30; i++) begin
         logic [3:0] op;
         logic [7:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = 8'($urandom);
         b  = 8'($urandom);
         send(op, a, b, model(op, a, b));
      end
      drain();

      // MUL latency: out_valid exactly 8 cycles after accept, in_ready low meanwhile,
      // operand changes after accept must not disturb the product.
      send(OP_MUL, 8'h13, 8'h11, {8'h43, 1'b0, 1'b1});
      in1 = 8'hFF; in2 = 8'hFF; opcode = OP_ADD;
      lat = 0;
      while (!out_valid && lat < 40) begin
         chk("mul_in_ready_low", in_ready, 0);
         @(posedge clk); #2;
         lat++;
      end
      chk("mul_latency", lat, 8);
      drain();

      // Back-pressure: five streamed ADDs, consumer stalls 3 cycles after the first result.
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               logic [7:0] a;
               a = 8'(8'h10 + 8'(i));
               send(OP_ADD, a, 8'h01, model(OP_ADD, a, 8'h01));
            end
         end
         begin
            t = 0;
            while (!out_valid && t < 20) begin
               @(posedge clk); #1;
               t++;
            end
            chk("bp_first_valid", out_valid, 1);
            hold = {result, zero, carry};
            chk("bp_first_value", {22'd0, hold}, {22'd0, 8'h11, 1'b0, 1'b0});
            repeat (3) begin
               @(posedge clk); #1;
               chk("bp_stable", {22'd0, result, zero, carry}, {22'd0, hold});
               chk("bp_valid_held", out_valid, 1);
               chk("bp_no_accept", in_ready, 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset in the middle of a multiply discards it.
      send(OP_MUL, 8'h13, 8'h11, {8'h43, 1'b0, 1'b1});
      repeat (3) begin
         @(posedge clk); #2;
      end
      rst = 1'b1;
      #1;
      chk("rst_mul_out_valid", out_valid, 0);
      chk("rst_mul_result", result, 0);
      chk("rst_mul_carry", carry, 0);
      chk("rst_mul_in_ready", in_ready, 1);
      n_drop += sb_q.size();
      sb_q.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #2;
         if (out_valid) seen = 1'b1;
      end
      chk("no_stale_mul", seen, 0);
      send(OP_ADD, 8'h21, 8'h12, {8'h33, 1'b0, 1'b0});
      send(OP_MUL, 8'h0B, 8'h03, {8'h21, 1'b0, 1'b0});
      drain();

      chk("delivered_count", n_pop, n_push - n_drop);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
